// File: rtl/sipo_frame_ctrl.sv
// Serial-in / parallel-out frame receiver: start bit, WIDTH data bits MSB-first,
// optional even parity, stop bit; delivers frames through a valid/ready slot.
module sipo_frame_ctrl #(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             bit_en,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             par_err,
  output logic             ovr_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_bad;
  logic             stop_strobe;
  logic             frame_good;
  logic             slot_free;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state defaults to hold before any branch, so no path leaves
  // state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    if (bit_en) begin
      unique case (state)
        IDLE:    if (!sin) state_next = SHIFT;
        SHIFT:   if (cnt == LAST_BIT) state_next = PARITY_EN ? PARITY : STOP;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign stop_strobe = bit_en && (state == STOP);
  assign frame_good  = sin && !par_bad;
  assign slot_free   = !po_valid || po_ready;

  // Counter saturates at the last data bit instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      cnt     <= '0;
      par_bad <= 1'b0;
    end else if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!sin) begin
            cnt     <= '0;
            par_bad <= 1'b0;
          end
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], sin};
          if (cnt != LAST_BIT) cnt <= cnt + 1'b1;
        end
        PARITY:  par_bad <= (^shreg) ^ sin;
        default: ;
      endcase
    end
  end

  // Error flags default low every cycle, which makes each one a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      po        <= '0;
      po_valid  <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      ovr_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      ovr_err   <= 1'b0;
      if (po_valid && po_ready) po_valid <= 1'b0;
      if (stop_strobe) begin
        if (frame_good) begin
          if (slot_free) begin
            po       <= shreg;
            po_valid <= 1'b1;
          end else begin
            ovr_err <= 1'b1;
          end
        end else begin
          frame_err <= !sin;
          par_err   <= par_bad;
        end
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=8, even parity) with immediate-assertion checks.
module tb_sipo_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       bit_en;
  logic [7:0] po;
  logic       po_valid;
  logic       po_ready;
  logic       busy;
  logic       frame_err;
  logic       par_err;
  logic       ovr_err;

  int total = 0;
  int bad   = 0;

  sipo_frame_ctrl #(.WIDTH(8), .PARITY_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .sin      (sin),
    .bit_en   (bit_en),
    .po       (po),
    .po_valid (po_valid),
    .po_ready (po_ready),
    .busy     (busy),
    .frame_err(frame_err),
    .par_err  (par_err),
    .ovr_err  (ovr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One bit period: sin changes a cycle before its strobe, strobe lasts one cycle.
  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    sin    = b;
    bit_en = 1'b0;
    @(negedge clk);
    bit_en   = 1'b1;
    po_ready = rdy;
    @(negedge clk);
    bit_en   = 1'b0;
    po_ready = 1'b0;
    sin      = 1'b1;
  endtask

  // Returns on the falling edge just after the stop-bit strobe edge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input logic rdy_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    send_bit(p, 1'b0);
    send_bit(s, rdy_at_stop);
  endtask

  task automatic chk_errs(input string tag, input logic fe, input logic pe, input logic oe);
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(fe));
    chk({tag, ".par_err"},   32'(par_err),   32'(pe));
    chk({tag, ".ovr_err"},   32'(ovr_err),   32'(oe));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    sin      = 1'b1;
    bit_en   = 1'b0;
    po_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.po", 32'(po), 32'h00);
    chk("rst.po_valid", 32'(po_valid), 32'h0);
    chk("rst.busy", 32'(busy), 32'h0);
    chk_errs("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle-high strobes must not start a frame.
    send_bit(1'b1, 1'b0);
    chk("idle.busy", 32'(busy), 32'h0);

    // Good frame 0xA5, even parity 0.
    send_bit(1'b0, 1'b0);
    chk("a5.busy_after_start", 32'(busy), 32'h1);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'hA5 >> i), 1'b0);
    send_bit(1'b0, 1'b0);
    chk("a5.no_valid_before_stop", 32'(po_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    chk("a5.po", 32'(po), 32'hA5);
    chk("a5.po_valid", 32'(po_valid), 32'h1);
    chk("a5.busy", 32'(busy), 32'h0);
    chk_errs("a5", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    po_ready = 1'b1;
    @(negedge clk);
    po_ready = 1'b0;
    chk("a5.valid_cleared", 32'(po_valid), 32'h0);
    chk("a5.po_held", 32'(po), 32'hA5);

    // Same frame, wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    chk_errs("par", 1'b0, 1'b1, 1'b0);
    chk("par.po_valid", 32'(po_valid), 32'h0);
    chk("par.busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("par.pulse_one_cycle", 32'(par_err), 32'h0);

    // 0x3C with stop bit low after a fresh reset.
    do_reset();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk_errs("stop0", 1'b1, 1'b0, 1'b0);
    chk("stop0.po", 32'(po), 32'h00);
    chk("stop0.po_valid", 32'(po_valid), 32'h0);
    @(negedge clk);
    chk("stop0.pulse_one_cycle", 32'(frame_err), 32'h0);

    // Stop low and parity bad together.
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    chk_errs("both", 1'b1, 1'b1, 1'b0);

    // Overrun: 0x11 then 0x22 with no ready.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    chk("ovr.first_po", 32'(po), 32'h11);
    chk("ovr.first_valid", 32'(po_valid), 32'h1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    chk_errs("ovr", 1'b0, 1'b0, 1'b1);
    chk("ovr.po_retained", 32'(po), 32'h11);
    chk("ovr.valid", 32'(po_valid), 32'h1);
    @(negedge clk);
    chk("ovr.pulse_one_cycle", 32'(ovr_err), 32'h0);
    po_ready = 1'b1;
    @(negedge clk);
    po_ready = 1'b0;
    chk("ovr.valid_cleared", 32'(po_valid), 32'h0);

    // Accept and reload in the same cycle.
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    chk("swap.first_valid", 32'(po_valid), 32'h1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    chk("swap.po", 32'(po), 32'h22);
    chk("swap.valid", 32'(po_valid), 32'h1);
    chk_errs("swap", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("swap.valid_holds", 32'(po_valid), 32'h1);
    po_ready = 1'b1;
    @(negedge clk);
    po_ready = 1'b0;

    // Reset mid-frame, coincident with a strobe, then a clean 0x5A.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    chk("abort.busy_before", 32'(busy), 32'h1);
    @(negedge clk);
    rst      = 1'b1;
    bit_en   = 1'b1;
    sin      = 1'b0;
    po_ready = 1'b1;
    @(negedge clk);
    chk("abort.busy_in_rst", 32'(busy), 32'h0);
    chk("abort.po_valid", 32'(po_valid), 32'h0);
    chk("abort.po", 32'(po), 32'h00);
    rst      = 1'b0;
    bit_en   = 1'b0;
    sin      = 1'b1;
    po_ready = 1'b0;
    @(negedge clk);
    chk("abort.busy_after", 32'(busy), 32'h0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("abort.po", 32'(po), 32'h5A);
    chk("abort.valid", 32'(po_valid), 32'h1);
    chk_errs("abort", 1'b0, 1'b0, 1'b0);
    chk("abort.busy_end", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, 8, number of data bits per frame (2..32).
REQ-002 Parameter PARITY_EN, 1, 1 = even-parity bit follows data, 0 = no parity bit.
REQ-003 The block SHALL have a single clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sin  input  1  serial data line, idle high.
REQ-007 bit_en  input  1  one-cycle sample strobe, one per bit period; sin sampled only when high.
REQ-008 po  output  WIDTH  parallel frame data, first-received bit at MSB.
REQ-009 po_valid  output  1  po holds an unaccepted frame.
REQ-010 po_ready  input  1  consumer accepts po when po_valid && po_ready.
REQ-011 busy  output  1  high whenever state != IDLE.
REQ-012 frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-013 par_err  output  1  one-cycle pulse, parity mismatch.
REQ-014 ovr_err  output  1  one-cycle pulse, completed frame dropped because po still occupied.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, PARITY, STOP; no transition occurs in a cycle with bit_en low.
REQ-016 IDLE: bit_en && sin==0 (start bit) -> SHIFT with bit counter = 0; bit_en && sin==1 -> stay IDLE.
REQ-017 SHIFT: on each bit_en, shift register <= {shreg[WIDTH-2:0], sin} and counter increments; on the WIDTH-th bit -> PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY: on bit_en, capture sin as parity bit; mismatch flag = (XOR of WIDTH data bits) ^ sin; -> STOP.
REQ-019 STOP: on bit_en -> IDLE always; frame is "good" if sin==1 and no parity mismatch.
REQ-020 Good frame with output slot free (po_valid==0, or po_valid && po_ready in the same cycle): po <= shreg, po_valid <= 1 in the next cycle (1-cycle latency from stop-bit strobe).
REQ-021 Good frame with po_valid==1 and po_ready==0: frame dropped, po unchanged, ovr_err pulses next cycle.
REQ-022 Stop bit low: frame dropped, frame_err pulses; if also parity mismatch, par_err pulses too; no ovr_err for dropped bad frames.
REQ-023 Stop bit high with parity mismatch: frame dropped, par_err pulses.
REQ-024 po_valid SHALL clear the cycle after po_valid && po_ready unless a good frame loads in that same cycle, in which case it stays high with the new po.
REQ-025 po SHALL hold its value until a new good frame loads; po_ready while po_valid==0 has no effect.
REQ-026 Error pulses SHALL be exactly one cycle wide and registered.
REQ-027 Shift and counter logic SHALL not wrap: counter range 0..WIDTH-1, reset to 0 on every IDLE->SHIFT.

Reset
REQ-028 rst SHALL force state IDLE, shift register 0, counter 0, po 0, po_valid 0, busy 0, all error pulses 0 on the next clock edge.
REQ-029 rst asserted mid-frame SHALL abort the frame with no po load and no error pulse; first bit_en after reset release is treated as IDLE sampling.
REQ-030 rst SHALL take priority over bit_en and po_ready in the same cycle.

Verification
REQ-031 WIDTH=8, PARITY_EN=1: start 0, bits 1,0,1,0,0,1,0,1, parity 0, stop 1 -> po=0xA5, po_valid=1 one cycle after stop strobe, no error pulses.
REQ-032 Same frame with parity bit 1 -> par_err single pulse, po_valid stays 0, busy low after stop strobe.
REQ-033 Frame 0x3C with stop bit 0 -> frame_err pulse, po unchanged (0), no po_valid.
REQ-034 Two good frames 0x11 then 0x22 with po_ready held 0 -> po=0x11 retained, ovr_err pulse after second stop; then po_ready=1 -> po_valid clears next cycle.
REQ-035 po_valid=1 (0x11) and po_ready=1 in the exact cycle the 0x22 stop strobe arrives -> po=0x22, po_valid stays 1, no ovr_err.
REQ-036 rst pulsed after 4 data bits of a frame, then full frame 0x5A sent -> only 0x5A delivered, no error pulses, busy low during/after reset.
